// File: rtl/mic_array_capture.sv
// mic_array_capture: I2S master capturing NUM_LINES stereo mic lines into a FWFT sample FIFO (optional MIC_ROUND_EN: round+saturate).
// Latency: a captured frame's 2*NUM_LINES words are written on the 2*NUM_LINES cycles after the WS 1->0 edge that closes it.
// Backpressure: out_valid/out_ready; a frame that does not fit in the FIFO is dropped whole and sets sticky overflow.

module mic_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           wr_dat,
  input  logic                   pop,
  output logic [W-1:0]           rd_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop && !empty;
  // a pop frees the head slot in the same cycle, so a full FIFO still accepts a push
  assign do_push = push && (!full || do_pop);
  assign rd_dat  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end
endmodule

module mic_array_capture #(
  parameter int NUM_LINES  = 4,
  parameter int DATAWIDTH  = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int SCK_DIV    = 30,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              capture_en,
  input  logic [NUM_LINES-1:0]              mic_data,
  output logic                              mic_sclk,
  output logic                              mic_ws,
  output logic signed [OUT_WIDTH-1:0]       out_data,
  output logic [$clog2(2*NUM_LINES)-1:0]    out_chan,
  output logic                              out_frame_start,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              overflow,
  input  logic                              ovf_clr
);
  localparam int NCH  = 2 * NUM_LINES;
  localparam int CHW  = $clog2(NCH);
  localparam int LW   = $clog2(FIFO_DEPTH) + 1;
  localparam int HALF = SCK_DIV / 2;
  localparam int DIVW = $clog2(HALF);

  typedef struct packed {
    logic [CHW-1:0]       chan;
    logic [OUT_WIDTH-1:0] dat;
  } smp_t;

  typedef enum logic {S_IDLE, S_PUSH} state_t;

  logic [DIVW-1:0]      div_cnt;
  logic                 div_wrap, sck_rise, sck_fall;
  logic [4:0]           slot_cnt;
  logic                 frame_start, sample_bit, cap_active, frame_done, space_ok;
  logic [DATAWIDTH-1:0] sh_l [NUM_LINES];
  logic [DATAWIDTH-1:0] sh_r [NUM_LINES];
  logic [OUT_WIDTH-1:0] red  [NCH];
  logic [OUT_WIDTH-1:0] hold [NCH];
  state_t               state, state_nxt;
  logic [CHW-1:0]       push_idx;
  logic                 last_push, push_vld, start_push, drop, fifo_empty;
  smp_t                 wr_ent, head;

  // bit clock: toggle every HALF cycles, strobes mark the cycle of each transition
  assign div_wrap = (div_cnt == DIVW'(HALF - 1));
  assign sck_rise = div_wrap && !mic_sclk;
  assign sck_fall = div_wrap && mic_sclk;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt  <= '0;
      mic_sclk <= 1'b0;
      slot_cnt <= '0;
      mic_ws   <= 1'b0;
    end else begin
      if (div_wrap) begin
        div_cnt  <= '0;
        mic_sclk <= ~mic_sclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (sck_fall) begin
        slot_cnt <= slot_cnt + 1'b1;
        if (slot_cnt == 5'd31) mic_ws <= ~mic_ws;
      end
    end
  end

  // WS 1->0 opens a frame and closes the previous one
  assign frame_start = sck_fall && (slot_cnt == 5'd31) && mic_ws;
  assign sample_bit  = sck_rise && ({1'b0, slot_cnt} < 6'(DATAWIDTH));
  assign frame_done  = frame_start && cap_active;
  assign space_ok    = (fifo_level <= LW'(FIFO_DEPTH - NCH));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cap_active <= 1'b0;
      for (int i = 0; i < NUM_LINES; i++) begin
        sh_l[i] <= '0;
        sh_r[i] <= '0;
      end
    end else begin
      if (frame_start) cap_active <= capture_en;
      if (sample_bit) begin
        for (int i = 0; i < NUM_LINES; i++) begin
          if (mic_ws) sh_r[i] <= {sh_r[i][DATAWIDTH-2:0], mic_data[i]};
          else        sh_l[i] <= {sh_l[i][DATAWIDTH-2:0], mic_data[i]};
        end
      end
    end
  end

`ifdef MIC_ROUND_EN
  localparam logic [DATAWIDTH:0] RND_BIAS = (DATAWIDTH+1)'(1) << (DATAWIDTH - OUT_WIDTH - 1);

  // only positive samples can carry into the sign bit, so overflow saturates to max positive
  function automatic logic [OUT_WIDTH-1:0] rnd_sat(input logic [DATAWIDTH-1:0] s);
    logic [DATAWIDTH:0] sum;
    sum = {s[DATAWIDTH-1], s} + RND_BIAS;
    if (sum[DATAWIDTH] != sum[DATAWIDTH-1]) rnd_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else                                    rnd_sat = sum[DATAWIDTH-1 -: OUT_WIDTH];
  endfunction
`endif

  always_comb begin
    for (int i = 0; i < NUM_LINES; i++) begin
`ifdef MIC_ROUND_EN
      red[2*i]   = rnd_sat(sh_l[i]);
      red[2*i+1] = rnd_sat(sh_r[i]);
`else
      red[2*i]   = sh_l[i][DATAWIDTH-1 -: OUT_WIDTH];
      red[2*i+1] = sh_r[i][DATAWIDTH-1 -: OUT_WIDTH];
`endif
    end
  end

  assign last_push = (push_idx == CHW'(NCH - 1));

  always_comb begin
    state_nxt  = state;
    push_vld   = 1'b0;
    start_push = 1'b0;
    drop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_done) begin
          if (space_ok) begin
            start_push = 1'b1;
            state_nxt  = S_PUSH;
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_PUSH: begin
        push_vld = 1'b1;
        if (last_push) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // the frame is snapshotted so the next frame's shifting cannot disturb the push
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      push_idx <= '0;
      overflow <= 1'b0;
      for (int c = 0; c < NCH; c++) hold[c] <= '0;
    end else begin
      state <= state_nxt;
      if (start_push) hold <= red;
      if (state == S_PUSH) push_idx <= last_push ? '0 : push_idx + 1'b1;
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign wr_ent = '{chan: push_idx, dat: hold[push_idx]};

  mic_fifo #(
    .W     ($bits(smp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .push   (push_vld),
    .wr_dat (wr_ent),
    .pop    (out_ready),
    .rd_dat (head),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign out_valid       = !fifo_empty;
  assign out_data        = fifo_empty ? '0 : head.dat;
  assign out_chan        = fifo_empty ? '0 : head.chan;
  assign out_frame_start = out_valid && (head.chan == '0);
endmodule
